// File: rtl/ccr_unit_pkg.sv
// ccr_unit_pkg
//   Shared definitions for the condition-code register slice:
//   - branch-type encodings carried on i_branch_type
//   - bit positions of the Z/N/C flags inside a packed 3-bit flag word
//   - a helper that evaluates a conditional jump against a flag word
package ccr_unit_pkg;

   typedef enum logic [1:0] {
      BR_JMP = 2'b00,
      BR_JZ  = 2'b01,
      BR_JN  = 2'b10,
      BR_JC  = 2'b11
   } br_type_e;

   localparam int unsigned FLAG_Z = 0;
   localparam int unsigned FLAG_N = 1;
   localparam int unsigned FLAG_C = 2;
   localparam int unsigned FLAG_W = 3;

   // Jump condition against a packed {C,N,Z} flag word.
   function automatic logic branch_cond(input logic [FLAG_W-1:0] flags,
                                        input logic [1:0]        btype);
      logic hit;
      hit = 1'b0;
      case (btype)
         BR_JMP:  hit = 1'b1;
         BR_JZ:   hit = flags[FLAG_Z];
         BR_JN:   hit = flags[FLAG_N];
         BR_JC:   hit = flags[FLAG_C];
         default: hit = 1'b0;
      endcase
      return hit;
   endfunction

endpackage

// File: rtl/ccr_unit_flag_stack.sv
// flag_stack
//   Small LIFO of 3-bit flag snapshots.
//   Ports:
//     clk, reset      clock, synchronous active-high reset (empties the stack)
//     push, push_data write push_data on top (ignored when full)
//     pop             discard top entry (ignored when empty)
//     top_data        current top entry (undefined content when empty)
//     full, empty     occupancy status
//     depth           number of occupied entries
//   A cycle with both push and pop changes nothing; the owner never issues
//   both together.
import ccr_unit_pkg::*;

module flag_stack #(
   parameter int unsigned DEPTH   = 2,
   parameter int unsigned DEPTH_W = $clog2(DEPTH + 1)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                push,
   input  logic [FLAG_W-1:0]   push_data,
   input  logic                pop,
   output logic [FLAG_W-1:0]   top_data,
   output logic                full,
   output logic                empty,
   output logic [DEPTH_W-1:0]  depth
);

   logic [FLAG_W-1:0]  mem [DEPTH];
   logic [DEPTH_W-1:0] count;

   logic do_push;
   logic do_pop;

   assign full    = (count == DEPTH_W'(DEPTH));
   assign empty   = (count == '0);
   assign depth   = count;
   assign do_push = push & ~pop & ~full;
   assign do_pop  = pop & ~push & ~empty;

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (do_push) begin
         count <= count + 1'b1;
      end else if (do_pop) begin
         count <= count - 1'b1;
      end
   end

   // Entry slot is selected by comparison rather than indexing so DEPTH=1
   // needs no zero-width index.
   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (reset) begin
            mem[i] <= '0;
         end else if (do_push && (count == DEPTH_W'(i))) begin
            mem[i] <= push_data;
         end
      end
   end

   always_comb begin
      top_data = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (count == DEPTH_W'(i + 1)) begin
            top_data = mem[i];
         end
      end
   end

endmodule

// File: rtl/ccr_unit.sv
// ccr_unit
//   Condition-code register for the execute-memory stage. Holds Z/N/C,
//   resolves conditional jumps from the held flags, clears the tested flag
//   on a taken jump, and saves/restores flags on interrupt entry/RTI.
//   Ports:
//     i_clk, i_reset                      clock, synchronous active-high reset
//     i_stall                             freeze flags, stack and errors
//     i_alu_valid, i_alu_z/n/c            ALU flag write
//     i_setc, i_clrc                      carry set/clear instructions
//     i_branch_valid, i_branch_type       branch present and its kind
//     i_int_save, i_int_restore           push / pop the flag snapshot
//     o_zero/negative/carry_flag          registered flags
//     o_branch_taken                      combinational jump decision
//     o_depth                             occupied save-stack entries
//     o_overflow/underflow/conflict       sticky error indications
import ccr_unit_pkg::*;

module ccr_unit #(
   parameter int unsigned SAVE_DEPTH = 2
) (
   input  logic                               i_clk,
   input  logic                               i_reset,
   input  logic                               i_stall,
   input  logic                               i_alu_valid,
   input  logic                               i_alu_z,
   input  logic                               i_alu_n,
   input  logic                               i_alu_c,
   input  logic                               i_setc,
   input  logic                               i_clrc,
   input  logic                               i_branch_valid,
   input  logic [1:0]                         i_branch_type,
   input  logic                               i_int_save,
   input  logic                               i_int_restore,
   output logic                               o_zero_flag,
   output logic                               o_negative_flag,
   output logic                               o_carry_flag,
   output logic                               o_branch_taken,
   output logic [$clog2(SAVE_DEPTH+1)-1:0]    o_depth,
   output logic                               o_overflow,
   output logic                               o_underflow,
   output logic                               o_conflict
);

   localparam int unsigned DEPTH_W = $clog2(SAVE_DEPTH + 1);

   logic [FLAG_W-1:0] flags_q;
   logic [FLAG_W-1:0] flags_d;
   logic [FLAG_W-1:0] stack_top;
   logic              stack_full;
   logic              stack_empty;

   logic save_req;
   logic restore_req;
   logic conflict_now;
   logic push_ok;
   logic pop_ok;
   logic overflow_now;
   logic underflow_now;

   logic overflow_q;
   logic underflow_q;
   logic conflict_q;

   assign o_zero_flag     = flags_q[FLAG_Z];
   assign o_negative_flag = flags_q[FLAG_N];
   assign o_carry_flag    = flags_q[FLAG_C];
   assign o_overflow      = overflow_q;
   assign o_underflow     = underflow_q;
   assign o_conflict      = conflict_q;

   assign o_branch_taken = i_branch_valid & branch_cond(flags_q, i_branch_type);

   // Requests during a stall are dropped; simultaneous save+restore cancels both.
   assign save_req      = i_int_save & ~i_stall;
   assign restore_req   = i_int_restore & ~i_stall;
   assign conflict_now  = save_req & restore_req;
   assign push_ok       = save_req & ~conflict_now & ~stack_full;
   assign pop_ok        = restore_req & ~conflict_now & ~stack_empty;
   assign overflow_now  = save_req & ~conflict_now & stack_full;
   assign underflow_now = restore_req & ~conflict_now & stack_empty;

   always_comb begin
      flags_d = flags_q;
      if (i_stall) begin
         flags_d = flags_q;
      end else if (restore_req && !conflict_now) begin
         // A restore against an empty stack leaves the flags untouched.
         flags_d = stack_empty ? flags_q : stack_top;
      end else if (i_alu_valid) begin
         flags_d[FLAG_Z] = i_alu_z;
         flags_d[FLAG_N] = i_alu_n;
         flags_d[FLAG_C] = i_alu_c;
      end else begin
         if (i_setc) begin
            flags_d[FLAG_C] = 1'b1;
         end else if (i_clrc) begin
            flags_d[FLAG_C] = 1'b0;
         end else if (o_branch_taken && (i_branch_type == BR_JC)) begin
            flags_d[FLAG_C] = 1'b0;
         end
         if (o_branch_taken && (i_branch_type == BR_JZ)) begin
            flags_d[FLAG_Z] = 1'b0;
         end
         if (o_branch_taken && (i_branch_type == BR_JN)) begin
            flags_d[FLAG_N] = 1'b0;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         flags_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
         conflict_q  <= 1'b0;
      end else begin
         flags_q <= flags_d;
         if (overflow_now)  overflow_q  <= 1'b1;
         if (underflow_now) underflow_q <= 1'b1;
         if (conflict_now)  conflict_q  <= 1'b1;
      end
   end

   flag_stack #(
      .DEPTH   (SAVE_DEPTH),
      .DEPTH_W (DEPTH_W)
   ) u_stack (
      .clk       (i_clk),
      .reset     (i_reset),
      .push      (push_ok),
      .push_data (flags_q),
      .pop       (pop_ok),
      .top_data  (stack_top),
      .full      (stack_full),
      .empty     (stack_empty),
      .depth     (o_depth)
   );

endmodule

// File: tb/tb_ccr_unit.sv
// tb_ccr_unit
//   Directed bench for ccr_unit (SAVE_DEPTH=2). The driver applies one
//   vector per cycle and queues the expected observation for that cycle;
//   a monitor pops and compares on the falling edge.
//   Expected word: {Z,N,C, depth[1:0], ovf, unf, cfl, taken}.
module tb_ccr_unit;

   logic       clk = 1'b0;
   logic       reset, stall, alu_valid, alu_z, alu_n, alu_c;
   logic       setc, clrc, branch_valid, int_save, int_restore;
   logic [1:0] branch_type;
   logic       zero_flag, negative_flag, carry_flag, branch_taken;
   logic [1:0] depth;
   logic       overflow, underflow, conflict;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string      name;
      logic [8:0] exp;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   ccr_unit #(.SAVE_DEPTH(2)) dut (
      .i_clk           (clk),
      .i_reset         (reset),
      .i_stall         (stall),
      .i_alu_valid     (alu_valid),
      .i_alu_z         (alu_z),
      .i_alu_n         (alu_n),
      .i_alu_c         (alu_c),
      .i_setc          (setc),
      .i_clrc          (clrc),
      .i_branch_valid  (branch_valid),
      .i_branch_type   (branch_type),
      .i_int_save      (int_save),
      .i_int_restore   (int_restore),
      .o_zero_flag     (zero_flag),
      .o_negative_flag (negative_flag),
      .o_carry_flag    (carry_flag),
      .o_branch_taken  (branch_taken),
      .o_depth         (depth),
      .o_overflow      (overflow),
      .o_underflow     (underflow),
      .o_conflict      (conflict)
   );

   // Monitor: one queued expectation per sampled cycle.
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         logic [8:0] act;
         e   = sb.pop_front();
         act = {zero_flag, negative_flag, carry_flag, depth,
                overflow, underflow, conflict, branch_taken};
         checks++;
         if (act !== e.exp) begin
            errors++;
            $display("FAIL %s: got ZNC=%b%b%b d=%0d ov=%b un=%b cf=%b tk=%b, want ZNC=%b d=%0d ov=%b un=%b cf=%b tk=%b",
                     e.name, act[8], act[7], act[6], act[5:4], act[3], act[2], act[1], act[0],
                     e.exp[8:6], e.exp[5:4], e.exp[3], e.exp[2], e.exp[1], e.exp[0]);
         end
      end
   end

   // rs st av z n c sc cc bv bt sv rt : inputs for this cycle
   // exp : observation during this cycle (state after the previous edge,
   //       branch decision for these inputs)
   task automatic drv(input logic rs, input logic st, input logic av,
                      input logic z, input logic n, input logic c,
                      input logic sc, input logic cc, input logic bv,
                      input logic [1:0] bt, input logic sv, input logic rt,
                      input bit chk, input string nm, input logic [8:0] exp);
      @(posedge clk);
      #1;
      reset = rs; stall = st; alu_valid = av; alu_z = z; alu_n = n; alu_c = c;
      setc = sc; clrc = cc; branch_valid = bv; branch_type = bt;
      int_save = sv; int_restore = rt;
      if (chk) sb.push_back('{nm, exp});
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; alu_valid = 1'b0; alu_z = 1'b0; alu_n = 1'b0;
      alu_c = 1'b0; setc = 1'b0; clrc = 1'b0; branch_valid = 1'b0;
      branch_type = 2'b00; int_save = 1'b0; int_restore = 1'b0;

      //   rs st av z n c sc cc bv bt     sv rt chk name                   ZNC d    ovf unf cfl tk
      drv(1, 0, 0, 0,0,0, 0, 0, 0, 2'b00, 0, 0, 0, "reset0",              9'b000_00_000_0);
      drv(1, 0, 0, 0,0,0, 0, 0, 0, 2'b00, 0, 0, 0, "reset1",              9'b000_00_000_0);
      drv(0, 0, 0, 0,0,0, 0, 0, 1, 2'b00, 0, 0, 1, "reset_state_jmp",     9'b000_00_000_1);
      drv(0, 0, 1, 1,0,1, 0, 0, 0, 2'b00, 0, 0, 1, "alu_write",           9'b000_00_000_0);
      drv(0, 0, 0, 0,0,0, 0, 0, 1, 2'b01, 0, 0, 1, "jz_taken",            9'b101_00_000_1);
      drv(0, 0, 0, 0,0,0, 0, 1, 0, 2'b00, 0, 0, 1, "jz_cleared_z",        9'b001_00_000_0);
      drv(0, 0, 0, 0,0,0, 0, 0, 1, 2'b11, 0, 0, 1, "jc_not_taken",        9'b000_00_000_0);
      drv(0, 0, 0, 0,0,0, 1, 1, 0, 2'b00, 0, 0, 1, "jc_left_flags",       9'b000_00_000_0);
      drv(0, 0, 1, 0,0,1, 0, 0, 1, 2'b11, 0, 0, 1, "setc_wins_jc_alu",    9'b001_00_000_1);
      drv(0, 0, 1, 0,0,1, 0, 1, 0, 2'b00, 0, 0, 1, "alu_beats_jc_clear",  9'b001_00_000_0);
      drv(0, 0, 1, 1,0,1, 0, 0, 0, 2'b00, 0, 0, 1, "alu_beats_clrc",      9'b001_00_000_0);
      drv(0, 0, 1, 0,1,0, 0, 0, 0, 2'b00, 1, 0, 1, "before_save1",        9'b101_00_000_0);
      drv(0, 0, 0, 0,0,0, 0, 0, 0, 2'b00, 1, 0, 1, "save1_and_alu",       9'b010_01_000_0);
      drv(0, 0, 0, 0,0,0, 0, 0, 0, 2'b00, 1, 0, 1, "save2",               9'b010_10_000_0);
      drv(0, 0, 1, 1,1,1, 0, 0, 0, 2'b00, 0, 0, 1, "overflow",            9'b010_10_100_0);
      drv(0, 0, 0, 0,0,0, 0, 0, 0, 2'b00, 0, 1, 1, "live_flags_111",      9'b111_10_100_0);
      drv(0, 0, 0, 0,0,0, 0, 0, 0, 2'b00, 0, 1, 1, "pop1",                9'b010_01_100_0);
      drv(0, 0, 0, 0,0,0, 0, 0, 0, 2'b00, 0, 1, 1, "pop2",                9'b101_00_100_0);
      drv(0, 0, 0, 0,0,0, 0, 0, 0, 2'b00, 1, 1, 1, "underflow_hold",      9'b101_00_110_0);
      drv(0, 1, 1, 0,1,0, 0, 0, 0, 2'b00, 1, 0, 1, "conflict",            9'b101_00_111_0);
      drv(0, 0, 0, 0,0,0, 0, 0, 0, 2'b00, 1, 0, 1, "stall_hold",          9'b101_00_111_0);
      drv(0, 0, 0, 0,0,0, 0, 0, 0, 2'b00, 1, 0, 1, "push_a",              9'b101_01_111_0);
      drv(1, 0, 0, 0,0,0, 0, 0, 0, 2'b00, 0, 0, 1, "push_b",              9'b101_10_111_0);
      drv(0, 0, 0, 0,0,0, 0, 0, 0, 2'b00, 0, 1, 1, "reset_mid_stack",     9'b000_00_000_0);
      drv(0, 0, 0, 0,0,0, 0, 0, 0, 2'b00, 0, 0, 1, "underflow_after_rst", 9'b000_00_010_0);

      @(posedge clk);
      @(negedge clk);
      #1;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
